// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX sequencing FSM; parity state gated by UART_TX_PARITY_EN
module uart_tx_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              par_typ,
    output logic [2:0]        mux_sel,
    output logic              ser_data,
    output logic              par_bit,
    output logic              busy,
    output logic              tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_START  = 3'b001,
        S_DATA   = 3'b010,
        S_PARITY = 3'b011,
        S_STOP   = 3'b100
    } state_t;

    state_t            state;
    logic [CW-1:0]     baud_cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign mux_sel   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            ser_data  <= 1'b0;
            par_bit   <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (data_valid) begin
                        shift_reg <= data_in;
                        par_bit   <= PAR_EN & (^data_in ^ par_typ);
                        state     <= S_START;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        ser_data  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            // next bit is loaded at the boundary so it holds for the whole period
                            bit_idx   <= bit_idx + 1'b1;
                            ser_data  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = DW + 2 + PAR;
    localparam int FLEN  = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          par_typ;
    logic [2:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;
    logic          tx_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int seen_par = 0;

    uart_tx_ctrl #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .par_typ    (par_typ),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (mux_sel == 3'b011) seen_par++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic line_of(input logic [2:0] m, input logic sd, input logic pb);
        case (m)
            3'b001:  return 1'b0;
            3'b010:  return sd;
            3'b011:  return pb;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic exp_line(input logic [DW-1:0] d, input logic pt, input int j);
        int b;
        b = j / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (PAR == 1 && b == DW + 1) return ^d ^ pt;
        return 1'b1;
    endfunction

    // Drive a request at a negedge; returns at the negedge just after the accept edge.
    task automatic start_frame(input logic [DW-1:0] d, input logic pt);
        @(negedge clk);
        data_in = d;
        par_typ = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Called at the negedge after the accept edge; checks every cycle of the frame and the done pulse.
    task automatic check_frame(input logic [DW-1:0] d, input logic pt, input bit glitch);
        check("start_visible", {29'd0, mux_sel}, 32'd1);
        for (int j = 0; j < FLEN; j++) begin
            if (j > 0) @(negedge clk);
            if (glitch && j == 10) begin
                data_in = 8'h3C;
                data_valid = 1'b1;
            end
            if (glitch && j == 11) data_valid = 1'b0;
            check($sformatf("line_%02h_c%0d", d, j), {31'd0, line_of(mux_sel, ser_data, par_bit)},
                  {31'd0, exp_line(d, pt, j)});
            check($sformatf("busy_%02h_c%0d", d, j), {31'd0, busy}, 32'd1);
            check($sformatf("nodone_%02h_c%0d", d, j), {31'd0, tx_done}, 32'd0);
        end
        @(negedge clk);
        check("done_pulse", {31'd0, tx_done}, 32'd1);
        check("done_idle", {29'd0, mux_sel}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("par_bit_held", {31'd0, par_bit}, (PAR == 1) ? {31'd0, ^d ^ pt} : 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        data_in = '0;
        data_valid = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mux", {29'd0, mux_sel}, 32'd0);
        check("rst_ser", {31'd0, ser_data}, 32'd0);
        check("rst_par", {31'd0, par_bit}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 even parity, full frame timing
        start_frame(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0);

        // 0x00 odd parity -> parity bit 1
        start_frame(8'h00, 1'b1);
        check_frame(8'h00, 1'b1, 1'b0);

        // request while busy is ignored
        @(posedge clk);
        d0 = done_cnt;
        start_frame(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        check("ignored_done_cnt", done_cnt - d0, 32'd1);
        check("ignored_idle", {29'd0, mux_sel}, 32'd0);

        // held valid -> back-to-back frames with one idle cycle
        @(posedge clk);
        d0 = done_cnt;
        @(negedge clk);
        data_in = 8'h11;
        par_typ = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h22;
        check_frame(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        check_frame(8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        check("b2b_done_cnt", done_cnt - d0, 32'd2);

        // reset during DATA bit 3 aborts the frame
        start_frame(8'hC3, 1'b0);
        for (int j = 1; j <= 4 * CPB + 1; j++) @(negedge clk);
        check("pre_rst_data", {29'd0, mux_sel}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_mux", {29'd0, mux_sel}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, tx_done}, 32'd0);
        check("abort_line", {31'd0, line_of(mux_sel, ser_data, par_bit)}, 32'd1);
        start_frame(8'h5A, 1'b1);
        check_frame(8'h5A, 1'b1, 1'b0);

        // all-ones frame; parity state presence matches the build
        seen_par = 0;
        start_frame(8'hFF, 1'b1);
        check_frame(8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        check("parity_state_seen", {31'd0, seen_par != 0}, (PAR == 1) ? 32'd1 : 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
